// File: rtl/timer_cmp_irq.sv
// Machine-timer compare stage: raises an interrupt when the upstream count reaches CMP,
// with one-shot / auto-reload modes, pending/ack handshake and a saturating overrun count.
module timer_cmp_irq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  input  logic             irq_ack,
  output logic             irq
);

  localparam int unsigned PAD_W  = WIDTH - OVR_W - 8;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    cmp_q, cmp_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic                pending_q, pending_d;
  logic [OVR_W-1:0]    ovr_q, ovr_d;

  logic [WIDTH-1:0]    diff;
  logic                match;
  logic                fire;
  logic                wr_ctrl, wr_cmp, wr_per, wr_stat;

  assign wr_ctrl = wr_en && (addr == 2'd0);
  assign wr_cmp  = wr_en && (addr == 2'd1);
  assign wr_per  = wr_en && (addr == 2'd2);
  assign wr_stat = wr_en && (addr == 2'd3);

  // Wrap-safe "reached": count is at or within half the range past CMP.
  assign diff  = count - cmp_q;
  assign match = ~diff[WIDTH-1];
  assign fire  = (state_q == ST_ARMED) && match && !wr_cmp && !wr_per;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      ctrl_q    <= '0;
      cmp_q     <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    cmp_d     = cmp_q;
    period_d  = period_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;

    case (state_q)
      ST_ARMED: if (fire && !ctrl_q[1]) state_d = ST_HOLD;
      ST_HOLD:  if (wr_cmp) state_d = ST_ARMED;
      default:  state_d = state_q;
    endcase

    // CTRL write overrides the FSM; re-enabling from HOLD keeps HOLD.
    if (wr_ctrl) begin
      ctrl_d = wr_data[CTRL_W-1:0];
      if (!wr_data[0]) begin
        state_d = ST_OFF;
      end else if (state_q == ST_OFF) begin
        state_d = ST_ARMED;
      end
    end

    if (wr_cmp) begin
      cmp_d = wr_data;
    end else if (fire && ctrl_q[1]) begin
      cmp_d = cmp_q + period_q;
    end

    if (wr_per) period_d = wr_data;

    // Fire has priority over ack and STATUS clear for pending.
    if (wr_stat && wr_data[0]) pending_d = 1'b0;
    if (irq_ack)               pending_d = 1'b0;
    if (fire)                  pending_d = 1'b1;

    if (wr_stat) begin
      ovr_d = '0;
    end else if (fire && pending_q && !irq_ack && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      2'd0:    rd_data = {{(WIDTH-CTRL_W){1'b0}}, ctrl_q};
      2'd1:    rd_data = cmp_q;
      2'd2:    rd_data = period_q;
      2'd3:    rd_data = {{PAD_W{1'b0}}, ovr_q, 5'b0, 2'(state_q), pending_q};
      default: rd_data = '0;
    endcase
  end

  assign irq = pending_q & ctrl_q[2];

endmodule
